// File: rtl/shift_ctrl.sv
// shift_ctrl: shift-enable/direction sequencer for the LED shift register.
// A prescaler makes a one-cycle tick at one of four rates. The lit-LED index
// is tracked so that bounce mode can reverse direction at either end.
module shift_ctrl #(
  parameter int unsigned     N_LEDS  = 4,
  parameter int unsigned     N_COUNT = 32,
  parameter longint unsigned LIM0    = 64'd8388607,
  parameter longint unsigned LIM1    = 64'd16777215,
  parameter longint unsigned LIM2    = 64'd33554431,
  parameter longint unsigned LIM3    = 64'd67108863,
  localparam int unsigned    POS_W   = $clog2(N_LEDS)
) (
  input  logic             clk,
  input  logic             i_ck_rst,
  input  logic             i_run,
  input  logic [1:0]       i_sel,
  input  logic             i_mode,
  input  logic             i_dir,
  output logic             o_shift_enable,
  output logic             o_shift_dir,
  output logic [POS_W-1:0] o_pos
);

  localparam logic [N_COUNT-1:0] L0      = N_COUNT'(LIM0);
  localparam logic [N_COUNT-1:0] L1      = N_COUNT'(LIM1);
  localparam logic [N_COUNT-1:0] L2      = N_COUNT'(LIM2);
  localparam logic [N_COUNT-1:0] L3      = N_COUNT'(LIM3);
  localparam logic [POS_W-1:0]   POS_MAX = POS_W'(N_LEDS - 1);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_FIXED  = 2'd1,
    ST_BOUNCE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_COUNT-1:0] cnt_q, cnt_d;
  logic               en_q, en_d;
  logic               dir_q, dir_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [N_COUNT-1:0] lim;
  logic [POS_W-1:0]   pos_nxt;

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clk or posedge i_ck_rst) begin
    if (i_ck_rst) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
    end
  end

  // Next state, prescaler, position and direction
  always_comb begin
    state_d = ST_STOP;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    dir_d   = dir_q;
    pos_d   = pos_q;
    lim     = L0;
    pos_nxt = pos_q;

    if (i_run) state_d = i_mode ? ST_BOUNCE : ST_FIXED;

    case (i_sel)
      2'd0:    lim = L0;
      2'd1:    lim = L1;
      2'd2:    lim = L2;
      default: lim = L3;
    endcase

    // Position follows every tick the shift register sees, so a tick
    // issued just before a pause is still accounted for.
    if (dir_q) pos_nxt = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
    else       pos_nxt = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
    if (en_q) pos_d = pos_nxt;

    case (state_q)
      ST_FIXED, ST_BOUNCE: begin
        if (cnt_q >= lim) begin
          cnt_d = '0;
          en_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + N_COUNT'(1);
        end
        if (state_q == ST_FIXED) begin
          // Direction is frozen on the tick edge so tick and dir stay paired
          if (!en_q) dir_d = i_dir;
        end else if (en_q) begin
          if (!dir_q && pos_nxt == POS_MAX) dir_d = 1'b1;
          else if (dir_q && pos_nxt == '0)  dir_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign o_shift_enable = en_q;
  assign o_shift_dir    = dir_q;
  assign o_pos          = pos_q;

endmodule
